// File: rtl/spi_master_cpha0_cpol1_if.sv
// spi_master_cpha0_cpol1_if: request/response and SPI line bundle for the SPI master.
// Defining SPI_MASTER_LOOPBACK_EN adds the IN_LOOPBACK request input.
interface spi_master_cpha0_cpol1_if #(parameter int PACK_LENGTH = 8);
  logic                   IN_START;
  logic [PACK_LENGTH-1:0] IN_TRANSMIT_DATA;
  logic                   MISO;
  logic                   MOSI;
  logic                   SCLK;
  logic                   CS;
  logic [PACK_LENGTH-1:0] OUT_RECEIVE_DATA;
  logic                   OUT_BUSY;
  logic                   OUT_DONE;
`ifdef SPI_MASTER_LOOPBACK_EN
  logic                   IN_LOOPBACK;
`endif
  modport master (
    input  IN_START, IN_TRANSMIT_DATA, MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
           IN_LOOPBACK,
`endif
    output MOSI, SCLK, CS, OUT_RECEIVE_DATA, OUT_BUSY, OUT_DONE
  );
  modport slave (
    output IN_START, IN_TRANSMIT_DATA, MISO,
`ifdef SPI_MASTER_LOOPBACK_EN
           IN_LOOPBACK,
`endif
    input  MOSI, SCLK, CS, OUT_RECEIVE_DATA, OUT_BUSY, OUT_DONE
  );
endinterface

// File: rtl/spi_master_cpha0_cpol1.sv
// spi_master_cpha0_cpol1: SPI master, CPOL=1 CPHA=0, MSB first, one full-duplex word per request.
// Defining SPI_MASTER_LOOPBACK_EN lets IN_LOOPBACK route the internal MOSI into the RX path.
module spi_master_cpha0_cpol1 #(
  parameter int PACK_LENGTH = 8,
  parameter int CLK_DIV     = 4
) (
  input  logic IN_CLK,
  input  logic IN_RESET,
  spi_master_cpha0_cpol1_if.master bus
);
  localparam int N  = PACK_LENGTH;
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(N) + 1;
  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD, GAP} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [N-1:0]   tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic           sclk_q, sclk_d, cs_q, cs_d, busy_q, busy_d, done_q, done_d;
  logic           last, accept, fall, rise, hold_end, gap_end, sample;
  assign last     = cnt_q == CW'(CLK_DIV - 1);
  assign accept   = state_q == IDLE && bus.IN_START;
  assign fall     = last && (state_q == SETUP || state_q == HIGH);
  assign rise     = last && state_q == LOW;
  assign hold_end = last && state_q == HOLD;
  assign gap_end  = last && state_q == GAP;
`ifdef SPI_MASTER_LOOPBACK_EN
  assign sample   = bus.IN_LOOPBACK ? tx_q[N-1] : bus.MISO;
`else
  assign sample   = bus.MISO;
`endif
  always_ff @(posedge IN_CLK or posedge IN_RESET)
    if (IN_RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      sclk_q  <= 1'b1;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  // Every non-idle phase lasts exactly CLK_DIV cycles; bit_q counts SCLK rises.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.IN_START ? SETUP : IDLE;
      SETUP:   state_d = last ? LOW : SETUP;
      LOW:     state_d = last ? (bit_q == BW'(N - 1) ? HOLD : HIGH) : LOW;
      HIGH:    state_d = last ? LOW : HIGH;
      HOLD:    state_d = last ? GAP : HOLD;
      GAP:     state_d = last ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // MOSI is the TX MSB, so clearing TX at the end of HOLD also parks MOSI low.
  always_comb begin
    cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    bit_d   = accept ? '0 : rise ? bit_q + 1'b1 : bit_q;
    tx_d    = accept ? bus.IN_TRANSMIT_DATA
            : (rise && bit_q != BW'(N - 1)) ? tx_q << 1
            : hold_end ? '0 : tx_q;
    rx_d    = accept ? '0 : fall ? {rx_q[N-2:0], sample} : rx_q;
    sclk_d  = fall ? 1'b0 : rise ? 1'b1 : sclk_q;
    cs_d    = accept ? 1'b0 : hold_end ? 1'b1 : cs_q;
    busy_d  = accept ? 1'b1 : gap_end ? 1'b0 : busy_q;
    done_d  = hold_end;
    rdata_d = hold_end ? rx_q : rdata_q;
  end
  assign bus.MOSI             = tx_q[N-1];
  assign bus.SCLK             = sclk_q;
  assign bus.CS               = cs_q;
  assign bus.OUT_RECEIVE_DATA = rdata_q;
  assign bus.OUT_BUSY         = busy_q;
  assign bus.OUT_DONE         = done_q;
endmodule

// File: tb/tb_spi_master_cpha0_cpol1.sv
// tb_spi_master_cpha0_cpol1: bench with a CPHA=0 slave model and a timing model of the master.
// Build with SPI_MASTER_LOOPBACK_EN to include the loopback cases.
module tb_spi_master_cpha0_cpol1;
  localparam int N = 8;
  localparam int D = 4;
  logic IN_CLK = 0, IN_RESET = 0, clk_en = 0;
  always #5 IN_CLK = clk_en ? ~IN_CLK : IN_CLK;
  spi_master_cpha0_cpol1_if #(.PACK_LENGTH(N)) bus ();
  spi_master_cpha0_cpol1 #(.PACK_LENGTH(N), .CLK_DIV(D)) dut (
    .IN_CLK(IN_CLK), .IN_RESET(IN_RESET), .bus(bus.master));
  // Slave: presents MSB when selected, advances on SCLK rise, samples MOSI on SCLK fall.
  logic [N-1:0] s_tx = 0, s_cur = 0, s_rx = 0;
  int s_idx = 0, falls = 0;
  always @(posedge bus.SCLK or posedge bus.CS) s_idx <= bus.CS ? 0 : s_idx + 1;
  always @(negedge bus.SCLK or negedge bus.CS)
    if (bus.SCLK) begin
      s_rx <= 0;
      falls <= 0;
      s_cur <= s_tx;
    end else if (!bus.CS) begin
      s_rx <= {s_rx[N-2:0], bus.MOSI};
      falls <= falls + 1;
    end
  assign bus.MISO = (!bus.CS && s_idx < N) ? s_cur[N-1-s_idx] : 1'b0;
  // Master model: remembers the accepting edge and the words in flight.
  int cyc = 0;
  always @(posedge IN_CLK) cyc <= cyc + 1;
  logic m_act = 0;
  int m_e0 = 0;
  logic [N-1:0] m_tx = 0, m_stx = 0, m_rd = 0;
  always @(posedge IN_CLK or posedge IN_RESET)
    if (IN_RESET) begin
      m_act <= 0;
      m_rd <= 0;
    end else begin
      if ((!m_act || cyc - m_e0 >= (2*N+2)*D) && bus.IN_START) begin
        m_act <= 1;
        m_e0 <= cyc + 1;
        m_tx <= bus.IN_TRANSMIT_DATA;
`ifdef SPI_MASTER_LOOPBACK_EN
        m_stx <= bus.IN_LOOPBACK ? bus.IN_TRANSMIT_DATA : s_tx;
`else
        m_stx <= s_tx;
`endif
      end
      if (m_act && cyc + 1 - m_e0 == (2*N+1)*D) m_rd <= m_stx;
    end
  int errors = 0, checks = 0, done_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  task automatic cmp_cycle();
    int rel = cyc - m_e0;
    logic inx = m_act && rel < (2*N+1)*D;
    int b = rel / (2*D);
    if (b > N-1) b = N-1;
    chk("cs", bus.CS, !inx);
    chk("sclk", bus.SCLK, !(inx && rel >= D && rel < 2*N*D && (rel-D) % (2*D) < D));
    chk("mosi", bus.MOSI, inx ? m_tx[N-1-b] : 1'b0);
    chk("busy", bus.OUT_BUSY, m_act && rel < (2*N+2)*D);
    chk("done", bus.OUT_DONE, m_act && rel == (2*N+1)*D);
    chk("rdata", bus.OUT_RECEIVE_DATA, m_rd);
    if (bus.OUT_DONE) begin
      done_cnt++;
      chk("slave_rx", s_rx, m_tx);
      chk("fall_count", falls, N);
    end
  endtask
  task automatic tick();
    @(negedge IN_CLK);
    cmp_cycle();
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask
  task automatic start(input logic [N-1:0] tx, input logic [N-1:0] stx, output int e0);
    int n = 0;
    while (bus.OUT_BUSY !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", n < 300, 1);
    bus.IN_TRANSMIT_DATA = tx;
    s_tx = stx;
    bus.IN_START = 1;
    tick();
    e0 = cyc;
    bus.IN_START = 0;
  endtask
  initial begin
    int e0, dc;
    bus.IN_START = 0;
    bus.IN_TRANSMIT_DATA = 0;
`ifdef SPI_MASTER_LOOPBACK_EN
    bus.IN_LOOPBACK = 0;
`endif
    #1 IN_RESET = 1;
    #1;
    chk("rst_cs", bus.CS, 1);
    chk("rst_sclk", bus.SCLK, 1);
    chk("rst_mosi", bus.MOSI, 0);
    chk("rst_busy", bus.OUT_BUSY, 0);
    chk("rst_done", bus.OUT_DONE, 0);
    chk("rst_rdata", bus.OUT_RECEIVE_DATA, 0);
    clk_en = 1;
    tick();
    tick();
    IN_RESET = 0;
    tick();
    // Full duplex 0xA5 out, 0x3C in
    start(8'hA5, 8'h3C, e0);
    wait_to(e0 + 3);
    chk("pre_fall_sclk", bus.SCLK, 1);
    wait_to(e0 + 4);
    chk("first_fall", bus.SCLK, 0);
    wait_to(e0 + 64);
    chk("last_rise", bus.SCLK, 1);
    wait_to(e0 + 67);
    chk("done_early", bus.OUT_DONE, 0);
    wait_to(e0 + 68);
    chk("done_at_68", bus.OUT_DONE, 1);
    chk("rx_3c", bus.OUT_RECEIVE_DATA, 8'h3C);
    chk("slave_a5", s_rx, 8'hA5);
    chk("falls_8", falls, 8);
    wait_to(e0 + 71);
    chk("busy_71", bus.OUT_BUSY, 1);
    wait_to(e0 + 72);
    chk("busy_low_72", bus.OUT_BUSY, 0);
    // Back-to-back with IN_START held high
    dc = done_cnt;
    start(8'hFF, 8'h12, e0);
    bus.IN_START = 1;
    wait_to(e0 + 5);
    bus.IN_TRANSMIT_DATA = 8'h00;
    s_tx = 8'h34;
    wait_to(e0 + 68);
    chk("b2b_rx1", bus.OUT_RECEIVE_DATA, 8'h12);
    chk("b2b_slave1", s_rx, 8'hFF);
    wait_to(e0 + 72);
    chk("b2b_cs_high", bus.CS, 1);
    wait_to(e0 + 73);
    chk("b2b_cs_fall_73", bus.CS, 0);
    bus.IN_START = 0;
    wait_to(e0 + 73 + 68);
    chk("b2b_rx2", bus.OUT_RECEIVE_DATA, 8'h34);
    chk("b2b_slave2", s_rx, 8'h00);
    chk("b2b_done_count", done_cnt - dc, 2);
    // Request and data change while busy are ignored
    start(8'h81, 8'h55, e0);
    wait_to(e0 + 20);
    bus.IN_START = 1;
    bus.IN_TRANSMIT_DATA = 8'h00;
    tick();
    bus.IN_START = 0;
    wait_to(e0 + 68);
    chk("ign_slave_81", s_rx, 8'h81);
    chk("ign_rx_55", bus.OUT_RECEIVE_DATA, 8'h55);
    wait_to(e0 + 80);
    chk("ign_no_restart_cs", bus.CS, 1);
    chk("ign_no_restart_busy", bus.OUT_BUSY, 0);
    // Reset in the middle of a transfer
    start(8'h33, 8'h99, e0);
    dc = done_cnt;
    wait_to(e0 + 30);
    IN_RESET = 1;
    #1;
    chk("mid_rst_cs", bus.CS, 1);
    chk("mid_rst_sclk", bus.SCLK, 1);
    chk("mid_rst_mosi", bus.MOSI, 0);
    chk("mid_rst_busy", bus.OUT_BUSY, 0);
    tick();
    IN_RESET = 0;
    wait_to(e0 + 80);
    chk("mid_rst_no_done", done_cnt - dc, 0);
    chk("mid_rst_rdata", bus.OUT_RECEIVE_DATA, 0);
    start(8'h5A, 8'hC3, e0);
    wait_to(e0 + 68);
    chk("post_rst_rx", bus.OUT_RECEIVE_DATA, 8'hC3);
    chk("post_rst_slave", s_rx, 8'h5A);
`ifdef SPI_MASTER_LOOPBACK_EN
    bus.IN_LOOPBACK = 1;
    start(8'h69, 8'h00, e0);
    wait_to(e0 + 68);
    chk("lb_on_rx", bus.OUT_RECEIVE_DATA, 8'h69);
    bus.IN_LOOPBACK = 0;
    start(8'h69, 8'h00, e0);
    wait_to(e0 + 68);
    chk("lb_off_rx", bus.OUT_RECEIVE_DATA, 8'h00);
`endif
    wait_to(cyc + 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
